// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one DII output channel between PORTS inputs.
// A grant is held from the first flit until the flit carrying last has transferred.
module dii_packet_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PORTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*WIDTH-1:0] in_data_i,
  input  logic [PORTS-1:0]       in_last_i,
  input  logic [PORTS-1:0]       in_valid_i,
  output logic [PORTS-1:0]       in_ready_o,
  output logic [WIDTH-1:0]       out_data_o,
  output logic                   out_last_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [PORTS-1:0]       grant_o,
  output logic                   busy_o
);

  localparam int unsigned PtrW = $clog2(PORTS);

  typedef enum logic [0:0] {StIdle, StPass} state_e;

  state_e            state_q;
  logic [PORTS-1:0]  grant_q;
  logic [PtrW-1:0]   last_port_q;
  logic              busy_q;

  logic [PtrW-1:0]   gnt_idx;
  logic [PtrW-1:0]   pick_idx;
  logic [PtrW-1:0]   scan_idx;
  logic              pick_vld;
  int unsigned       scan_pos;
  logic              xfer_last;

  // Output mux driven by the one-hot grant; an all-zero grant yields an idle channel.
  always_comb begin
    out_data_o  = '0;
    out_last_o  = 1'b0;
    out_valid_o = 1'b0;
    gnt_idx     = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        out_data_o  = out_data_o | in_data_i[i*WIDTH +: WIDTH];
        out_last_o  = out_last_o | in_last_i[i];
        out_valid_o = out_valid_o | in_valid_i[i];
        gnt_idx     = gnt_idx | PtrW'(i);
      end
    end
  end

  assign in_ready_o = grant_q & {PORTS{out_ready_i}};
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign xfer_last  = out_valid_o & out_ready_i & out_last_o;

  // Scan downward so the port nearest above last_port_q is the final (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_pos = 0;
    scan_idx = '0;
    for (int unsigned k = PORTS; k >= 1; k--) begin
      scan_pos = 32'(last_port_q) + k;
      if (scan_pos >= PORTS) begin
        scan_pos = scan_pos - PORTS;
      end
      scan_idx = PtrW'(scan_pos);
      if (in_valid_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      last_port_q <= PtrW'(PORTS - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            state_q <= StPass;
            grant_q <= PORTS'(1) << pick_idx;
            busy_q  <= 1'b1;
          end
        end
        StPass: begin
          // Pointer moves only on packet completion, never on grant.
          if (xfer_last) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            last_port_q <= gnt_idx;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Directed testbench for dii_packet_arbiter (4 ports, 16-bit flits).
module tb_dii_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [3:0]  in_last = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int failures = 0;

  dii_packet_arbiter #(.WIDTH(16), .PORTS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'hF;
    in_last = 4'hF;
    in_data = 64'h3333_2222_1111_0000;
    out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || grant !== 4'b0 || in_ready !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold valid=%b grant=%b ready=%b busy=%b required 0/0000/0000/0",
               out_valid, grant, in_ready, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || in_ready !== 4'b0001 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant grant=%b busy=%b ready=%b valid=%b required 0001/1/0001/1",
               grant, busy, in_ready, out_valid);
    end
  endtask

  task automatic test_fairness();
    int cnt[4];
    int phase;
    int port;
    logic [15:0] exp_data;
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    for (int c = 0; c < 32; c++) begin
      for (int p = 0; p < 4; p++) begin
        in_valid[p] = 1'b1;
        in_last[p] = (cnt[p] % 3 == 2);
        in_data[p*16 +: 16] = {4'(p), 8'h00, 4'(cnt[p] % 3)};
      end
      #1;
      phase = c % 4;
      port = (c / 4) % 4;
      checks++;
      if (phase == 0) begin
        if (grant !== 4'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL fairness_bubble c=%0d grant=%b valid=%b busy=%b required 0000/0/0",
                   c, grant, out_valid, busy);
        end
      end else begin
        exp_data = {4'(port), 8'h00, 4'(phase - 1)};
        if (grant !== (4'b0001 << port) || out_valid !== 1'b1 || out_data !== exp_data ||
            out_last !== (phase == 3) || busy !== 1'b1) begin
          failures++;
          $display("FAIL fairness_flit c=%0d grant=%b data=%h last=%b required %b/%h/%b",
                   c, grant, out_data, out_last, 4'b0001 << port, exp_data, phase == 3);
        end
      end
      for (int p = 0; p < 4; p++) if (in_ready[p] && in_valid[p]) cnt[p]++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    int rx;
    int m;
    bit done;
    do_reset();
    cnt = 0;
    rx = 0;
    m = -1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      out_ready = (c % 3 == 0);
      in_valid[2] = (cnt < 5);
      in_last[2] = (cnt == 4);
      in_data[32 +: 16] = 16'h2A00 | 16'(cnt);
      in_valid[0] = (c >= 4);
      in_last[0] = 1'b1;
      in_data[0 +: 16] = 16'h0B00;
      #1;
      if (m < 0) begin
        if (c >= 1) begin
          checks++;
          if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL bp_grant_hold c=%0d grant=%b required 0100", c, grant);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (out_data !== (16'h2A00 | 16'(rx)) || out_last !== (rx == 4)) begin
            failures++;
            $display("FAIL bp_flit c=%0d data=%h last=%b required %h/%b",
                     c, out_data, out_last, 16'h2A00 | 16'(rx), rx == 4);
          end
          if (rx == 4) m = c;
          rx++;
        end
      end else if (c == m + 1) begin
        checks++;
        if (grant !== 4'b0000) begin
          failures++;
          $display("FAIL bp_bubble c=%0d grant=%b required 0000", c, grant);
        end
      end else if (c == m + 2) begin
        checks++;
        if (grant !== 4'b0001) begin
          failures++;
          $display("FAIL bp_next_grant c=%0d grant=%b required 0001", c, grant);
        end
        done = 1'b1;
      end
      if (in_ready[2] && in_valid[2]) cnt++;
      tick();
    end
    checks++;
    if (!done || rx != 5 || m != 15) begin
      failures++;
      $display("FAIL bp_complete done=%0d flits=%0d last_cycle=%0d required 1/5/15", done, rx, m);
    end
  endtask

  task automatic test_single();
    int n;
    int xfers;
    logic [3:0] exp_grant;
    do_reset();
    out_ready = 1'b1;
    n = 0;
    xfers = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid[3] = (n < 10);
      in_last[3] = 1'b1;
      in_data[48 +: 16] = 16'h3000 | 16'(n);
      #1;
      exp_grant = (c % 2 == 1) ? 4'b1000 : 4'b0000;
      checks++;
      if (grant !== exp_grant) begin
        failures++;
        $display("FAIL single_grant c=%0d grant=%b required %b", c, grant, exp_grant);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== (16'h3000 | 16'(n)) || out_last !== 1'b1) begin
          failures++;
          $display("FAIL single_flit c=%0d data=%h required %h", c, out_data, 16'h3000 | 16'(n));
        end
        xfers++;
        n++;
      end
      tick();
    end
    checks++;
    if (xfers != 10) begin
      failures++;
      $display("FAIL single_count xfers=%0d required 10", xfers);
    end
  endtask

  task automatic test_valid_gap();
    int cnt;
    int exp_f[8] = '{0, 0, 1, 0, 0, 0, 2, 3};
    do_reset();
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid[1] = (cnt < 4) && !(c >= 3 && c <= 5);
      in_last[1] = (cnt == 3);
      in_data[16 +: 16] = 16'h1C00 | 16'(cnt);
      for (int p = 0; p < 4; p++) begin
        if (p != 1) begin
          in_valid[p] = (c >= 1);
          in_last[p] = 1'b1;
          in_data[p*16 +: 16] = 16'h0D00 | 16'(p);
        end
      end
      #1;
      if (c >= 1 && c <= 7) begin
        checks++;
        if (grant !== 4'b0010 || in_ready !== 4'b0010) begin
          failures++;
          $display("FAIL gap_grant c=%0d grant=%b ready=%b required 0010/0010", c, grant, in_ready);
        end
        checks++;
        if (c >= 3 && c <= 5) begin
          if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL gap_valid c=%0d valid=%b required 0", c, out_valid);
          end
        end else if (out_valid !== 1'b1 || out_data !== (16'h1C00 | 16'(exp_f[c])) ||
                     out_last !== (c == 7)) begin
          failures++;
          $display("FAIL gap_flit c=%0d valid=%b data=%h last=%b required 1/%h/%b",
                   c, out_valid, out_data, out_last, 16'h1C00 | 16'(exp_f[c]), c == 7);
        end
      end else if (c == 8) begin
        checks++;
        if (grant !== 4'b0000) begin
          failures++;
          $display("FAIL gap_bubble grant=%b required 0000", grant);
        end
      end else if (c == 9) begin
        checks++;
        if (grant !== 4'b0100) begin
          failures++;
          $display("FAIL gap_next_rr grant=%b required 0100", grant);
        end
      end
      if (in_ready[1] && in_valid[1]) cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    in_last = 4'b0001;
    in_data[0 +: 16] = 16'h0E00;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: in_valid = 4'b0001;
        1: begin in_valid = 4'b0011; in_data[16 +: 16] = 16'h1F00; end
        2: in_valid = 4'b0010;
        3: in_data[16 +: 16] = 16'h1F00;
        4: in_data[16 +: 16] = 16'h1F01;
        5: begin rst = 1'b1; in_valid = 4'b0011; in_data[16 +: 16] = 16'h1F02; end
        6: begin rst = 1'b0; in_data[16 +: 16] = 16'h1F00; end
        default: ;
      endcase
      #1;
      case (c)
        1: begin
          checks++;
          if (grant !== 4'b0001 || out_data !== 16'h0E00) begin
            failures++;
            $display("FAIL rmid_pre grant=%b data=%h required 0001/0e00", grant, out_data);
          end
        end
        3, 4: begin
          checks++;
          if (grant !== 4'b0010 || out_data !== (16'h1F00 | 16'(c - 3))) begin
            failures++;
            $display("FAIL rmid_flit c=%0d grant=%b data=%h required 0010/%h",
                     c, grant, out_data, 16'h1F00 | 16'(c - 3));
          end
        end
        6: begin
          checks++;
          if (out_valid !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || in_ready !== 4'b0) begin
            failures++;
            $display("FAIL rmid_idle valid=%b grant=%b busy=%b ready=%b required 0/0000/0/0000",
                     out_valid, grant, busy, in_ready);
          end
        end
        7: begin
          checks++;
          if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_ptr_restart grant=%b required 0001", grant);
          end
        end
        default: ;
      endcase
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_single();
    test_valid_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
